// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between NR round-robin read ports and one write port.
// Writes normally win; a starvation guard hands reads one cycle after STARVE consecutive losses.
module mem_port_arbiter #(
    parameter int NR     = 3,
    parameter int AW     = 28,
    parameter int DW     = 128,
    parameter int RL     = 1,
    parameter int STARVE = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NR-1:0]       rd_req,
    input  logic [NR*AW-1:0]    rd_addr,
    output logic [NR-1:0]       rd_gnt,
    output logic [NR-1:0]       rd_valid,
    output logic [NR*DW-1:0]    rd_data,
    input  logic                wr_req,
    input  logic [AW-1:0]       wr_addr,
    input  logic [DW-1:0]       wr_data,
    input  logic [DW/8-1:0]     wr_strb,
    output logic                wr_gnt,
    output logic                mem_ren,
    output logic                mem_wen,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    output logic [DW/8-1:0]     mem_strb,
    input  logic [DW-1:0]       mem_rdata
);
    localparam int PW = (NR > 1) ? $clog2(NR) : 1;
    localparam int SW = $clog2(STARVE + 1);

    logic [PW-1:0]         ptr_r;
    logic [PW-1:0]         rd_idx_s;
    logic [PW-1:0]         ptr_nxt_s;
    logic [SW-1:0]         starv_r;
    logic                  rd_found_s;
    logic                  any_rd_s;
    logic                  starved_s;
    logic                  wr_win_s;
    logic                  rd_win_s;
    logic [RL-1:0]         pipe_v_r;
    logic [RL-1:0][PW-1:0] pipe_id_r;

    // Grants are gated by rstn so nothing reaches the memory while in reset.
    assign any_rd_s  = |rd_req;
    assign starved_s = any_rd_s && (starv_r == SW'(STARVE));
    assign wr_win_s  = rstn && wr_req && !starved_s;
    assign rd_win_s  = rstn && rd_found_s && !wr_win_s;
    assign ptr_nxt_s = (rd_idx_s == PW'(NR - 1)) ? '0 : rd_idx_s + PW'(1);

    // Round-robin search: first requesting port at or after ptr_r.
    always_comb begin
        int j;
        j          = 0;
        rd_found_s = 1'b0;
        rd_idx_s   = '0;
        for (int k = 0; k < NR; k++) begin
            j = (int'(ptr_r) + k) % NR;
            if (!rd_found_s && rd_req[j]) begin
                rd_found_s = 1'b1;
                rd_idx_s   = PW'(j);
            end else begin
                rd_idx_s   = rd_idx_s;
            end
        end
    end

    // One-hot read grant for the winning port.
    always_comb begin
        rd_gnt = '0;
        if (rd_win_s) begin
            rd_gnt[rd_idx_s] = 1'b1;
        end else begin
            rd_gnt = '0;
        end
    end

    // Memory command mux; idle cycles drive zeros on address, data and strobes.
    always_comb begin
        wr_gnt    = wr_win_s;
        mem_wen   = wr_win_s;
        mem_ren   = rd_win_s;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_strb  = '0;
        if (wr_win_s) begin
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
            mem_strb  = wr_strb;
        end else if (rd_win_s) begin
            mem_addr  = rd_addr[int'(rd_idx_s)*AW +: AW];
        end else begin
            mem_addr  = '0;
        end
    end

    // Round-robin pointer and write-over-read starvation counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_r   <= '0;
            starv_r <= '0;
        end else begin
            if (rd_win_s) begin
                ptr_r <= ptr_nxt_s;
            end
            if (wr_win_s && any_rd_s) begin
                if (starv_r != SW'(STARVE)) begin
                    starv_r <= starv_r + SW'(1);
                end
            end else begin
                starv_r <= '0;
            end
        end
    end

    // Latency pipe: tail stage is valid in the cycle mem_rdata belongs to that read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pipe_v_r  <= '0;
            pipe_id_r <= '0;
        end else begin
            pipe_v_r[0]  <= rd_win_s;
            pipe_id_r[0] <= rd_idx_s;
            for (int k = 1; k < RL; k++) begin
                pipe_v_r[k]  <= pipe_v_r[k-1];
                pipe_id_r[k] <= pipe_id_r[k-1];
            end
        end
    end

    // Return stage: capture memory data into the owning port and pulse its valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_valid <= '0;
            rd_data  <= '0;
        end else begin
            rd_valid <= '0;
            if (pipe_v_r[RL-1]) begin
                rd_valid[pipe_id_r[RL-1]]                   <= 1'b1;
                rd_data[int'(pipe_id_r[RL-1])*DW +: DW]     <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed table, corner sequences and random traffic against
// a transaction-level model (RL=1 instance) plus a latency probe on an RL=3 instance.
module tb_mem_port_arbiter;
    localparam int NR     = 3;
    localparam int AW     = 8;
    localparam int DW     = 128;
    localparam int BW     = DW / 8;
    localparam int RL1    = 1;
    localparam int STARVE = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstn;
    logic [NR-1:0]     rd_req, rd_gnt, rd_valid;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic              wr_req, wr_gnt, mem_ren, mem_wen;
    logic [AW-1:0]     wr_addr, mem_addr;
    logic [DW-1:0]     wr_data, mem_wdata, mem_rdata;
    logic [BW-1:0]     wr_strb, mem_strb;

    logic [NR-1:0]     rd_req_b, rd_gnt_b, rd_valid_b;
    logic [NR*AW-1:0]  rd_addr_b;
    logic [NR*DW-1:0]  rd_data_b;
    logic              wr_gnt_b, mem_ren_b, mem_wen_b;
    logic [AW-1:0]     mem_addr_b;
    logic [DW-1:0]     mem_wdata_b, mem_rdata_b;
    logic [BW-1:0]     mem_strb_b;
    logic [31:0]       tcyc = 32'd0;

    mem_port_arbiter #(.NR(NR), .AW(AW), .DW(DW), .RL(RL1), .STARVE(STARVE)) dut (
        .clk(clk), .rstn(rstn), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_gnt(wr_gnt), .mem_ren(mem_ren),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_strb(mem_strb),
        .mem_rdata(mem_rdata));

    mem_port_arbiter #(.NR(NR), .AW(AW), .DW(DW), .RL(3), .STARVE(STARVE)) dut3 (
        .clk(clk), .rstn(rstn), .rd_req(rd_req_b), .rd_addr(rd_addr_b), .rd_gnt(rd_gnt_b),
        .rd_valid(rd_valid_b), .rd_data(rd_data_b), .wr_req(1'b0), .wr_addr({AW{1'b0}}),
        .wr_data({DW{1'b0}}), .wr_strb({BW{1'b0}}), .wr_gnt(wr_gnt_b), .mem_ren(mem_ren_b),
        .mem_wen(mem_wen_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_strb(mem_strb_b),
        .mem_rdata(mem_rdata_b));

    // Memory behind the RL=1 instance: write-before-read, one-cycle read latency.
    logic [DW-1:0] phys_mem [256];
    always @(posedge clk) begin
        if (mem_wen) begin
            for (int b = 0; b < BW; b++) begin
                if (mem_strb[b]) phys_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        if (mem_ren) mem_rdata <= phys_mem[mem_addr];
    end

    // The RL=3 instance reads a cycle stamp, so the captured value shows the sampling cycle.
    always @(posedge clk) tcyc <= tcyc + 32'd1;
    assign mem_rdata_b = {96'd0, tcyc};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input int a);
        logic [31:0] s;
        s = 32'(a) * 32'h9E37_79B9 + 32'h1234_5678;
        return {s, ~s, s ^ 32'hFFFF_0000, s + 32'd7};
    endfunction

    // Transaction-level reference model.
    typedef struct { int port; int due; logic [DW-1:0] data; } ret_t;
    ret_t            q[$];
    logic [DW-1:0]   ref_mem [256];
    logic [NR*DW-1:0] exp_data;
    logic [NR-1:0]   m_gnt_last;
    int              m_ptr, m_starv, cyc;

    task automatic model_step();
        logic          any, exp_w;
        int            gi, j;
        logic [NR-1:0] eg, ev;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [BW-1:0] es;
        ret_t          r;
        any   = |rd_req;
        exp_w = wr_req && !(m_starv == STARVE && any);
        gi    = -1;
        if (!exp_w) begin
            for (int k = 0; k < NR; k++) begin
                j = (m_ptr + k) % NR;
                if (gi < 0 && rd_req[j]) gi = j;
            end
        end
        eg = '0;
        ea = '0; ed = '0; es = '0;
        if (gi >= 0) eg[gi] = 1'b1;
        if (exp_w) begin
            ea = wr_addr; ed = wr_data; es = wr_strb;
        end else if (gi >= 0) begin
            ea = rd_addr[gi*AW +: AW];
        end
        chk("rd_gnt", rd_gnt, eg);
        chk("wr_gnt", wr_gnt, exp_w);
        chk("mem_wen", mem_wen, exp_w);
        chk("mem_ren", mem_ren, gi >= 0);
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ed);
        chk("mem_strb", mem_strb, es);
        ev = '0;
        while (q.size() > 0 && q[0].due == cyc) begin
            r = q.pop_front();
            ev[r.port] = 1'b1;
            exp_data[r.port*DW +: DW] = r.data;
        end
        chk("rd_valid", rd_valid, ev);
        chk("rd_data", rd_data, exp_data);
        if (gi >= 0) begin
            q.push_back('{port: gi, due: cyc + RL1 + 1, data: ref_mem[ea]});
            m_ptr = (gi + 1) % NR;
        end
        if (exp_w) begin
            for (int b = 0; b < BW; b++) begin
                if (es[b]) ref_mem[ea][8*b +: 8] = ed[8*b +: 8];
            end
        end
        m_starv    = (exp_w && any) ? ((m_starv < STARVE) ? m_starv + 1 : STARVE) : 0;
        m_gnt_last = eg;
        cyc++;
    endtask

    task automatic model_reset();
        q.delete();
        m_ptr = 0; m_starv = 0; exp_data = '0; m_gnt_last = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct { logic [NR-1:0] rd; logic wr; logic [NR-1:0] g; logic w; } vec_t;
    vec_t tbl [20];

    initial begin
        logic [DW-1:0] iv;
        logic [31:0]   g, r32;

        tbl[0]  = '{3'b111, 1'b0, 3'b001, 1'b0};
        tbl[1]  = '{3'b111, 1'b0, 3'b010, 1'b0};
        tbl[2]  = '{3'b111, 1'b0, 3'b100, 1'b0};
        tbl[3]  = '{3'b111, 1'b0, 3'b001, 1'b0};
        tbl[4]  = '{3'b010, 1'b1, 3'b000, 1'b1};
        tbl[5]  = '{3'b010, 1'b1, 3'b000, 1'b1};
        tbl[6]  = '{3'b010, 1'b1, 3'b000, 1'b1};
        tbl[7]  = '{3'b010, 1'b1, 3'b000, 1'b1};
        tbl[8]  = '{3'b010, 1'b1, 3'b010, 1'b0};
        tbl[9]  = '{3'b010, 1'b1, 3'b000, 1'b1};
        tbl[10] = '{3'b000, 1'b1, 3'b000, 1'b1};
        tbl[11] = '{3'b011, 1'b1, 3'b000, 1'b1};
        tbl[12] = '{3'b000, 1'b0, 3'b000, 1'b0};
        tbl[13] = '{3'b100, 1'b0, 3'b100, 1'b0};
        tbl[14] = '{3'b011, 1'b0, 3'b001, 1'b0};
        tbl[15] = '{3'b010, 1'b0, 3'b010, 1'b0};
        tbl[16] = '{3'b101, 1'b0, 3'b100, 1'b0};
        tbl[17] = '{3'b001, 1'b0, 3'b001, 1'b0};
        tbl[18] = '{3'b000, 1'b0, 3'b000, 1'b0};
        tbl[19] = '{3'b000, 1'b0, 3'b000, 1'b0};

        rstn = 1'b0;
        rd_req = '0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
        rd_req_b = '0; rd_addr_b = '0;
        for (int a = 0; a < 256; a++) begin
            phys_mem[a] = init_val(a);
            ref_mem[a]  = init_val(a);
        end
        cyc = 0;
        model_reset();

        // Requests raised while in reset must not be granted.
        #7;
        rd_req = 3'b111; wr_req = 1'b1; rd_req_b = 3'b001;
        #1;
        chk("reset_rd_gnt", rd_gnt, 0);
        chk("reset_wr_gnt", wr_gnt, 0);
        chk("reset_mem_en", {mem_ren, mem_wen, mem_ren_b}, 0);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_rd_data", rd_data, 0);
        rd_req = '0; wr_req = 1'b0; rd_req_b = '0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (3) tick();

        // Directed table: round robin from ptr 0, starvation guard, withdrawal.
        rd_addr = {8'h30, 8'h20, 8'h10};
        for (int i = 0; i < 20; i++) begin
            rd_req  = tbl[i].rd;
            wr_req  = tbl[i].wr;
            wr_addr = 8'h40 + 8'(i);
            wr_data = {4{32'(i) * 32'h0101_0101}};
            wr_strb = '1;
            @(negedge clk);
            chk($sformatf("tbl%0d_rd_gnt", i), rd_gnt, tbl[i].g);
            chk($sformatf("tbl%0d_wr_gnt", i), wr_gnt, tbl[i].w);
            model_step();
            @(posedge clk);
            #1;
        end

        // Partial-strobe write followed by a read of the same word on port 2.
        wr_req = 1'b1; wr_addr = 8'd5; wr_data = {DW{1'b1}} & {16{8'hAA}}; wr_strb = 16'h000F;
        tick();
        wr_req = 1'b0; wr_strb = '0;
        rd_req = 3'b100; rd_addr[2*AW +: AW] = 8'd5;
        tick();
        rd_req = '0;
        repeat (2) tick();
        iv = init_val(5);
        chk("strb_merge", rd_data[2*DW +: DW], {iv[DW-1:32], 32'hAAAA_AAAA});

        // RL=3 instance: valid exactly four cycles after the grant, data from the sampling cycle.
        rd_req_b = 3'b001; rd_addr_b = '0;
        @(negedge clk);
        chk("rl3_gnt", rd_gnt_b, 3'b001);
        g = tcyc;
        model_step();
        @(posedge clk);
        #1 rd_req_b = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("rl3_valid_k%0d", k), rd_valid_b, (k == 4) ? 3'b001 : 3'b000);
            if (k >= 4) chk($sformatf("rl3_data_k%0d", k), rd_data_b[DW-1:0], {96'd0, g + 32'd3});
            model_step();
            @(posedge clk);
            #1;
        end

        // Reset one cycle after a read grant: the read must never return.
        rd_req = 3'b001; rd_addr[0 +: AW] = 8'h10;
        tick();
        rd_req = 3'b011; wr_req = 1'b1;
        #1 rstn = 1'b0;
        #1;
        chk("midrst_rd_gnt", rd_gnt, 0);
        chk("midrst_wr_gnt", wr_gnt, 0);
        chk("midrst_mem_en", {mem_ren, mem_wen}, 0);
        chk("midrst_rd_valid", rd_valid, 0);
        chk("midrst_rd_data", rd_data, 0);
        rd_req = '0; wr_req = 1'b0;
        @(posedge clk);
        #2 rstn = 1'b1;
        model_reset();
        repeat (4) tick();
        rd_req = 3'b010; rd_addr[AW +: AW] = 8'h20;
        tick();
        rd_req = '0;
        repeat (3) tick();

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            for (int p = 0; p < NR; p++) begin
                if (rd_req[p] && !m_gnt_last[p]) begin
                    if ($urandom_range(0, 15) == 0) rd_req[p] = 1'b0;
                end else begin
                    rd_req[p] = ($urandom_range(0, 2) != 0);
                    rd_addr[p*AW +: AW] = AW'($urandom_range(0, 15));
                end
            end
            r32     = $urandom;
            wr_req  = ($urandom_range(0, 9) < 6);
            wr_addr = {4'd0, r32[3:0]};
            wr_data = {$urandom, $urandom, $urandom, $urandom};
            wr_strb = r32[31:16];
            tick();
        end
        rd_req = '0; wr_req = 1'b0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised successor to the fixed three-reader/one-writer word-port memory servicing used around the systolic-array DMA engines.
- Merges NR read ports (mm2s-style: request, word address) and one write port (s2mm-style: request, address, data, byte strobe) onto a single shared single-port memory.
- Adds per-port grant backpressure, round-robin read fairness, write-over-read priority with a starvation guard, and a configurable memory read latency.

Parameters:
- NR, 3, number of read ports (1..8).
- AW, 28, word address width (AXI_ADDR_WIDTH minus log2 of bytes per word).
- DW, 128, data width in bits, multiple of 8.
- RL, 1, memory read latency in cycles: mem_rdata is valid RL cycles after the mem_ren cycle (1..4).
- STARVE, 4, consecutive cycles a pending read may lose to writes before reads are forced to win one cycle (≥1).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- rd_req  in  NR  per-port read request; must stay high with a stable address until granted.
- rd_addr  in  NR*AW  per-port word address; port i occupies bits [i*AW +: AW].
- rd_gnt  out  NR  one-hot or zero; combinational grant in the request cycle.
- rd_valid  out  NR  registered; one-cycle pulse when data returns to port i.
- rd_data  out  NR*DW  registered per-port data; holds its last value.
- wr_req  in  1  write request.
- wr_addr  in  AW  write word address.
- wr_data  in  DW  write data.
- wr_strb  in  DW/8  write byte enables.
- wr_gnt  out  1  combinational write grant.
- mem_ren  out  1  memory read enable.
- mem_wen  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_strb  out  DW/8  memory byte enables.
- mem_rdata  in  DW  memory read data.

Behaviour:
- Single clock domain; reset is asynchronous and active-low on rstn.
- Reset clears: RR pointer to 0, starvation counter, latency pipe, rd_valid, rd_data. rd_gnt, wr_gnt, mem_ren and mem_wen are forced to 0 while rstn=0.
- Memory usage: at most one memory operation per cycle; mem_ren and mem_wen are never both high.
- Write vs read: a write wins when wr_req=1, unless starv_cnt==STARVE and some rd_req is high; then a read wins and starv_cnt clears.
- Starvation counter:
  - Increments on each cycle a write is granted while any rd_req is pending (saturates at STARVE).
  - Clears on any read grant, or on any cycle with no pending read.
- Read arbitration: round-robin. The search starts at ptr; the first requesting port i is granted. On a grant, ptr becomes (i+1) mod NR; otherwise ptr holds.
- Memory outputs on a grant:
  - Write grant: mem_wen=1, mem_addr=wr_addr, mem_wdata=wr_data, mem_strb=wr_strb.
  - Read grant: mem_ren=1, mem_addr=rd_addr[i], mem_strb=0.
  - No grant: mem_addr, mem_wdata and mem_strb are 0.
- Latency pipe: a shift register RL+1 deep carrying {valid, port id}.
  - Read granted in cycle t: mem_rdata is sampled at the end of cycle t+RL.
  - rd_data[i] and rd_valid[i] are visible in cycle t+RL+1, so total latency is RL+1 cycles.
- Throughput: back-to-back reads give one rd_valid per cycle; returns are in grant order.
- Write-then-read to the same address in consecutive cycles returns the new data. No internal forwarding is done; this relies on memory write-before-read order.
- Reset mid-operation drops all in-flight reads; no rd_valid is asserted after rstn rises for requests granted before reset.
- rd_req deasserted before grant: the request is withdrawn with no side effect.

Test Plan:
- Reset then idle: rd_valid=0, rd_data=0, mem_ren=mem_wen=0, ptr=0; assert rstn low asynchronously mid-cycle and confirm outputs clear immediately.
- All NR=3 reads held high to addrs 0x10, 0x20, 0x30, RL=1: grants in order 0,1,2,0,…; rd_valid[0] in cycle 2 with mem[0x10], one valid per cycle thereafter.
- wr_req held high plus rd_req[1] high, STARVE=4: wr_gnt for 4 cycles, then rd_gnt[1] on cycle 5, then writes resume; starv_cnt clears on the read grant.
- Write 0xAA..AA with wr_strb=0x000F to addr 5, then read port 2 addr 5 the next cycle: rd_data[2] has low 4 bytes 0xAA and the other bytes unchanged.
- RL=3, single read granted at cycle 10: rd_valid pulses in cycle 14 only; rd_data holds afterwards.
- Grant a read at cycle t, pull rstn low at t+1 and release at t+2: no rd_valid ever appears for that read; the next read after reset is serviced normally.
